// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Show-ahead instruction buffer; flush wins over push and pop in the same cycle.
module ifetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !flush;
    assign w_pop  = pop && !flush && (r_count != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited sequential imem reads, in-order response buffering, redirect with wrong-path drop.
module ifetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] inst_word,
    output logic        inst_valid,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;
    logic          r_running;

    logic [31:0]   w_target;
    logic [CW:0]   w_occ;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    fetch_entry_t  w_entry;
    fetch_entry_t  w_head;

    assign w_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_occ    = {1'b0, r_inflight} + {1'b0, w_count};

    // Credits cover both queued and outstanding words, so a response always has a free slot.
    assign imem_req  = r_running && !redirect_valid && (w_occ < DEPTH_W);
    assign imem_addr = r_fetch_pc;
    assign w_ack     = imem_req && imem_ack;

    assign w_push  = imem_rvalid && !redirect_valid && (r_drop_cnt == '0);
    assign w_entry = {r_resp_pc, imem_rdata};

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_ack && !imem_rvalid)      w_inflight_nxt = r_inflight + CW'(1);
        else if (!w_ack && imem_rvalid) w_inflight_nxt = r_inflight - CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_running  <= 1'b0;
        end else begin
            assert (!(w_push && w_full));
            r_running  <= 1'b1;
            r_inflight <= w_inflight_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= w_inflight_nxt;
            end else begin
                if (w_ack)  r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc  <= r_resp_pc + 32'd4;
                if (imem_rvalid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (w_entry),
        .pop     (w_pop),
        .flush   (redirect_valid),
        .head    (w_head),
        .count   (w_count),
        .empty   (w_empty),
        .full    (w_full)
    );

    assign inst_valid = !w_empty && !redirect_valid;
    assign w_pop      = inst_valid && inst_ready;
    assign pc         = inst_valid ? w_head.pc   : '0;
    assign inst_word  = inst_valid ? w_head.word : '0;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: per-cycle vector tables plus hand-written redirect/wrap/reset sequences.
module tb_ifetch;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc;
    logic [31:0] inst_word;
    logic        inst_valid;
    logic        inst_ready = 1'b1;

    always #5 clock = ~clock;

    ifetch #(
        .RESET_PC   (32'hBFC0_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .inst_word      (inst_word),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready)
    );

    // imem model: fixed latency, in-order, one response per cycle, rdata = addr ^ FFFFFFFF
    typedef struct {
        logic [31:0] addr;
        int unsigned wt;
    } pend_t;

    pend_t       mq[$];
    pend_t       mq_tmp;
    int unsigned lat = 1;
    logic        ack_en = 1'b1;

    assign imem_ack = ack_en;

    always @(posedge clock) begin
        if (!reset_n) begin
            mq.delete();
        end else begin
            if (imem_rvalid && mq.size() > 0) mq_tmp = mq.pop_front();
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].wt > 0) mq[i].wt = mq[i].wt - 1;
            if (imem_req && imem_ack) begin
                mq_tmp.addr = imem_addr;
                mq_tmp.wt   = lat - 1;
                mq.push_back(mq_tmp);
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && mq.size() > 0 && mq[0].wt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr ^ 32'hFFFF_FFFF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    int unsigned nvec = 0;
    int unsigned nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_word);
        nvec++;
        if (imem_req !== e_req || imem_addr !== e_addr || inst_valid !== e_valid ||
            pc !== e_pc || inst_word !== e_word) begin
            nfail++;
            $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h word=%h expected req=%b addr=%h valid=%b pc=%h word=%h",
                     nm, imem_req, imem_addr, inst_valid, pc, inst_word, e_req, e_addr, e_valid, e_pc, e_word);
        end
    endtask

    // Ends at a falling edge with reset_n just released, before the first rising edge of run.
    task automatic do_reset();
        @(negedge clock);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2 chk_outs("reset_state", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          restart;
        int unsigned reps;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rs, int unsigned reps, logic rdy, logic req,
                                logic [31:0] addr, logic v, logic [31:0] p);
        vec_t t;
        t.restart = rs; t.reps = reps; t.ready = rdy;
        t.req = req; t.addr = addr; t.valid = v; t.pc = p;
        return t;
    endfunction

    initial begin
        int n;
        bit found;
        logic [31:0] ew;

        // streaming with 1-cycle imem, decode always ready
        tv.push_back(mk(1, 1,  1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0000));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0004));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0008));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_000C));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0018, 1'b1, 32'hBFC0_0010));
        // 20-cycle stall: four requests, then credits exhausted; then in-order drain
        tv.push_back(mk(1, 1,  1'b0, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0));
        tv.push_back(mk(0, 1,  1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0));
        tv.push_back(mk(0, 1,  1'b0, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0));
        tv.push_back(mk(0, 1,  1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0000));
        tv.push_back(mk(0, 1,  1'b0, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0000));
        tv.push_back(mk(0, 1,  1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0000));
        tv.push_back(mk(0, 15, 1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0000));
        tv.push_back(mk(0, 1,  1'b1, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_0000));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0004));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_0008));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0018, 1'b1, 32'hBFC0_000C));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_001C, 1'b1, 32'hBFC0_0010));
        tv.push_back(mk(0, 1,  1'b1, 1'b1, 32'hBFC0_0020, 1'b1, 32'hBFC0_0014));

        lat = 1; ack_en = 1'b1;
        for (int k = 0; k < tv.size(); k++) begin
            if (tv[k].restart) do_reset();
            for (int r = 0; r < int'(tv[k].reps); r++) begin
                inst_ready = tv[k].ready;
                ew = tv[k].valid ? (tv[k].pc ^ 32'hFFFF_FFFF) : 32'h0;
                #2 chk_outs($sformatf("vec%0d_%0d", k, r), tv[k].req, tv[k].addr, tv[k].valid, tv[k].pc, ew);
                @(negedge clock);
            end
        end

        // 3-cycle imem, redirect with two wrong-path reads outstanding
        lat = 3; ack_en = 1'b1; inst_ready = 1'b1;
        do_reset();
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        ack_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0003;
        #2 chk("t3_redir_req", {31'b0, imem_req}, 32'h0);
        chk("t3_redir_valid", {31'b0, inst_valid}, 32'h0);
        @(negedge clock);
        redirect_valid = 1'b0; ack_en = 1'b1;
        #2 chk("t3_first_addr", imem_req ? imem_addr : 32'hDEAD_BEEF, 32'h0040_0000);
        n = 0; found = 0;
        while (!found && n < 20) begin
            @(negedge clock);
            n++;
            #2 if (inst_valid) found = 1;
        end
        chk("t3_cycles", n, 32'd4);
        chk("t3_pc", pc, 32'h0040_0000);
        chk("t3_word", inst_word, 32'hFFBF_FFFF);

        // redirect coincident with an rvalid, then a second redirect the next cycle
        lat = 1; ack_en = 1'b1; inst_ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clock);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        #2 chk_outs("t4_redir1", 1'b0, 32'hBFC0_0014, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        redirect_pc = 32'h0000_2000;
        #2 chk_outs("t4_redir2", 1'b0, 32'h0000_1000, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        redirect_valid = 1'b0;
        #2 chk_outs("t4_c2", 1'b1, 32'h0000_2000, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        #2 chk_outs("t4_c3", 1'b1, 32'h0000_2004, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        #2 chk_outs("t4_c4", 1'b1, 32'h0000_2008, 1'b1, 32'h0000_2000, 32'hFFFF_DFFF);
        @(negedge clock);
        #2 chk_outs("t4_c5", 1'b1, 32'h0000_200C, 1'b1, 32'h0000_2004, 32'hFFFF_DFFB);

        // fetch address wraps at the top of the address space
        @(negedge clock);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #2 chk("t5_redir_req", {31'b0, imem_req}, 32'h0);
        @(negedge clock);
        redirect_valid = 1'b0;
        #2 chk_outs("t5_r1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        #2 chk_outs("t5_r2", 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        #2 chk_outs("t5_r3", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'h0000_0003);
        @(negedge clock);
        #2 chk_outs("t5_r4", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);

        // fill the buffer, then async reset mid-cycle and restart
        @(negedge clock);
        inst_ready = 1'b0;
        repeat (8) @(negedge clock);
        #2 chk("t6_full_valid", {31'b0, inst_valid}, 32'h1);
        chk("t6_full_req", {31'b0, imem_req}, 32'h0);
        reset_n = 1'b0;
        #1 chk_outs("t6_async", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        inst_ready = 1'b1; reset_n = 1'b1;
        #2 chk_outs("t6_rel", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        #2 chk_outs("t6_c0", 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        #2 chk_outs("t6_c2", 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0000, 32'h403F_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
